// File: rtl/generic_rr_sel_n_arb.sv
// rtl/generic_rr_sel_n_arb.sv - multi-grant round-robin arbiter packing up to NUM_SEL requests per cycle
// One registered output bundle; priority rotates to just past the last requester served.
module generic_rr_sel_n_arb #(
  parameter int WIDTH      = 8,
  parameter int SIZE       = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SEL    = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [WIDTH-1:0]                    req_vld,
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0]    req_data,
  output logic [WIDTH-1:0]                    req_gnt,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [NUM_SEL-1:0]                  out_slot_vld,
  output logic [NUM_SEL-1:0][DATA_WIDTH-1:0]  out_data,
  output logic [NUM_SEL-1:0][SIZE-1:0]        out_idx,
  output logic [SIZE-1:0]                     rr_ptr
);

  logic                               out_vld_q, out_vld_d;
  logic [NUM_SEL-1:0]                 slot_vld_q, slot_vld_d;
  logic [NUM_SEL-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_SEL-1:0][SIZE-1:0]       idx_q, idx_d;
  logic [SIZE-1:0]                    rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0]                   rot, rem, sel_mask;
  logic [NUM_SEL-1:0][SIZE-1:0]       enc, sel_idx;
  logic [NUM_SEL-1:0]                 sel_vld;
  logic [SIZE:0]                      sum;
  logic [SIZE-1:0]                    last_idx, nxt_ptr;
  logic                               found, load;

  // Rotate so rr_ptr lands on bit 0, then peel off the lowest set bits one slot at a time.
  always_comb begin
    rot     = WIDTH'({req_vld, req_vld} >> rr_ptr_q);
    rem     = rot;
    enc     = '0;
    sel_vld = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_SEL; k++) begin
      found = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if (!found && rem[j]) begin
          found  = 1'b1;
          enc[k] = SIZE'(j);
          rem[j] = 1'b0;
        end
      end
      sel_vld[k] = found;
    end
  end

  // Un-rotate with an explicit wrap so non-power-of-2 WIDTH stays correct.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    last_idx = '0;
    sum      = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      sum = {1'b0, enc[k]} + {1'b0, rr_ptr_q};
      if (sel_vld[k]) begin
        sel_idx[k] = (sum >= (SIZE+1)'(WIDTH)) ? SIZE'(sum - (SIZE+1)'(WIDTH)) : SIZE'(sum);
        sel_mask[sel_idx[k]] = 1'b1;
        last_idx = sel_idx[k];
      end
    end
    nxt_ptr = (last_idx == SIZE'(WIDTH-1)) ? '0 : last_idx + 1'b1;
  end

  assign load    = ~reset & enable & (~out_vld_q | out_rdy) & (|req_vld);
  assign req_gnt = load ? sel_mask : '0;

  always_comb begin
    out_vld_d  = out_vld_q;
    slot_vld_d = slot_vld_q;
    data_d     = data_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      out_vld_d  = 1'b1;
      slot_vld_d = sel_vld;
      idx_d      = sel_idx;
      rr_ptr_d   = nxt_ptr;
      for (int k = 0; k < NUM_SEL; k++) begin
        data_d[k] = sel_vld[k] ? req_data[sel_idx[k]] : '0;
      end
    end else if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
      slot_vld_d = '0;
      data_d     = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      slot_vld_q <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      slot_vld_q <= slot_vld_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_slot_vld = slot_vld_q;
  assign out_data     = data_q;
  assign out_idx      = idx_q;
  assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_generic_rr_sel_n_arb.sv
// tb/tb_generic_rr_sel_n_arb.sv - directed self-checking bench for generic_rr_sel_n_arb
// Second instance with WIDTH=6 covers the non-power-of-2 wrap.
module tb_generic_rr_sel_n_arb;

  logic             clk = 1'b0;
  logic             reset, enable, out_rdy, out_vld;
  logic [7:0]       req_vld, req_gnt;
  logic [7:0][3:0]  req_data;
  logic [2:0]       out_slot_vld;
  logic [2:0][3:0]  out_data;
  logic [2:0][2:0]  out_idx;
  logic [2:0]       rr_ptr;

  logic [5:0]       req_vld6, req_gnt6;
  logic [5:0][3:0]  req_data6;
  logic             out_vld6;
  logic [2:0]       out_slot_vld6;
  logic [2:0][3:0]  out_data6;
  logic [2:0][2:0]  out_idx6;
  logic [2:0]       rr_ptr6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generic_rr_sel_n_arb #(.WIDTH(8), .DATA_WIDTH(4), .NUM_SEL(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_vld(req_vld), .req_data(req_data),
    .req_gnt(req_gnt), .out_vld(out_vld), .out_rdy(out_rdy), .out_slot_vld(out_slot_vld),
    .out_data(out_data), .out_idx(out_idx), .rr_ptr(rr_ptr)
  );

  generic_rr_sel_n_arb #(.WIDTH(6), .DATA_WIDTH(4), .NUM_SEL(3)) dut6 (
    .clk(clk), .reset(reset), .enable(enable), .req_vld(req_vld6), .req_data(req_data6),
    .req_gnt(req_gnt6), .out_vld(out_vld6), .out_rdy(out_rdy), .out_slot_vld(out_slot_vld6),
    .out_data(out_data6), .out_idx(out_idx6), .rr_ptr(rr_ptr6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic vld, input logic [2:0] sv,
                            input logic [8:0] idx, input logic [11:0] dat, input logic [2:0] ptr);
    chk({tag, "_vld"},  64'(out_vld), 64'(vld));
    chk({tag, "_slot"}, 64'(out_slot_vld), 64'(sv));
    chk({tag, "_idx"},  64'(out_idx), 64'(idx));
    chk({tag, "_data"}, 64'(out_data), 64'(dat));
    chk({tag, "_ptr"},  64'(rr_ptr), 64'(ptr));
  endtask

  function automatic logic [7:0] rr_mask(input int p);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 3; k++) m[(p + k) % 8] = 1'b1;
    return m;
  endfunction

  initial begin
    int cnt [8];
    int p, loads, cyc;
    logic vm;
    logic [7:0] exp_g;

    for (int i = 0; i < 8; i++) req_data[i] = 4'(i + 8);
    for (int i = 0; i < 6; i++) req_data6[i] = 4'(i + 1);
    reset = 1'b1; enable = 1'b1; out_rdy = 1'b1; req_vld = 8'hFF; req_vld6 = '0;
    #1 chk("reset_gnt", 64'(req_gnt), 64'h0);
    tick();
    chk("reset_gnt2", 64'(req_gnt), 64'h0);
    tick();
    reset = 1'b0; req_vld = '0;
    #1 chk_bundle("post_reset", 1'b0, 3'b000, 9'h0, 12'h0, 3'd0);

    req_vld = 8'b1011_0110;
    #1 chk("basic_gnt", 64'(req_gnt), 64'b0001_0110);
    tick();
    chk_bundle("basic", 1'b1, 3'b111, {3'd4, 3'd2, 3'd1}, {4'hC, 4'hA, 4'h9}, 3'd5);

    req_vld = 8'b1000_0011;
    #1 chk("wrap_gnt", 64'(req_gnt), 64'b1000_0011);
    tick();
    chk_bundle("wrap", 1'b1, 3'b111, {3'd1, 3'd0, 3'd7}, {4'h9, 4'h8, 4'hF}, 3'd2);

    req_vld = 8'b0100_0000;
    #1 chk("sparse_gnt", 64'(req_gnt), 64'b0100_0000);
    tick();
    chk_bundle("sparse", 1'b1, 3'b001, {3'd0, 3'd0, 3'd6}, {4'h0, 4'h0, 4'hE}, 3'd7);

    req_vld = '0;
    #1 chk("idle_gnt", 64'(req_gnt), 64'h0);
    tick();
    chk_bundle("idle_drain", 1'b0, 3'b000, 9'h0, 12'h0, 3'd7);

    req_vld = 8'hFF;
    #1 chk("bp_load_gnt", 64'(req_gnt), 64'b1000_0011);
    tick();
    chk_bundle("bp_load", 1'b1, 3'b111, {3'd1, 3'd0, 3'd7}, {4'h9, 4'h8, 4'hF}, 3'd2);
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_gnt", 64'(req_gnt), 64'h0);
      tick();
      chk_bundle("bp_hold", 1'b1, 3'b111, {3'd1, 3'd0, 3'd7}, {4'h9, 4'h8, 4'hF}, 3'd2);
    end
    out_rdy = 1'b1;
    #1 chk("bp_release_gnt", 64'(req_gnt), 64'b0001_1100);
    tick();
    chk_bundle("bp_release", 1'b1, 3'b111, {3'd4, 3'd3, 3'd2}, {4'hC, 4'hB, 4'hA}, 3'd5);

    enable = 1'b0;
    #1 chk("dis_gnt", 64'(req_gnt), 64'h0);
    tick();
    chk_bundle("dis_drain", 1'b0, 3'b000, 9'h0, 12'h0, 3'd5);
    enable = 1'b1;

    #1 chk("rst_pre_gnt", 64'(req_gnt), 64'b1110_0000);
    tick();
    chk("rst_pre_ptr", 64'(rr_ptr), 64'd0);
    #1 chk("rst_pre2_gnt", 64'(req_gnt), 64'b0000_0111);
    tick();
    chk_bundle("rst_pre2", 1'b1, 3'b111, {3'd2, 3'd1, 3'd0}, {4'hA, 4'h9, 4'h8}, 3'd3);
    out_rdy = 1'b0;
    tick();
    chk("rst_held_vld", 64'(out_vld), 64'd1);
    reset = 1'b1; out_rdy = 1'b1;
    #1 chk("rst_mid_gnt", 64'(req_gnt), 64'h0);
    tick();
    reset = 1'b0; req_vld = '0;
    #1 chk_bundle("rst_mid", 1'b0, 3'b000, 9'h0, 12'h0, 3'd0);

    for (int i = 0; i < 8; i++) cnt[i] = 0;
    p = 0; loads = 0; cyc = 0; vm = 1'b0;
    req_vld = 8'hFF;
    while (loads < 8 && cyc < 200) begin
      out_rdy = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) req_data[i] = 4'($urandom_range(0, 15));
      #1;
      exp_g = (!vm || out_rdy) ? rr_mask(p) : 8'h0;
      chk("fair_gnt", 64'(req_gnt), 64'(exp_g));
      if (exp_g != 8'h0) begin
        for (int i = 0; i < 8; i++) if (req_gnt[i]) cnt[i]++;
        loads++;
        p = (p + 3) % 8;
        vm = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("fair_loads", 64'(loads), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'd3);
    out_rdy = 1'b1; req_vld = '0;
    tick();

    req_vld6 = 6'b01_0000;
    #1 chk("w6_a_gnt", 64'(req_gnt6), 64'b01_0000);
    tick();
    chk("w6_a_ptr", 64'(rr_ptr6), 64'd5);
    chk("w6_a_idx", 64'(out_idx6), 64'({3'd0, 3'd0, 3'd4}));
    req_vld6 = 6'b10_0001;
    #1 chk("w6_b_gnt", 64'(req_gnt6), 64'b10_0001);
    tick();
    chk("w6_b_slot", 64'(out_slot_vld6), 64'b011);
    chk("w6_b_idx", 64'(out_idx6), 64'({3'd0, 3'd0, 3'd5}));
    chk("w6_b_data", 64'(out_data6), 64'({4'h0, 4'h1, 4'h6}));
    chk("w6_b_ptr", 64'(rr_ptr6), 64'd1);
    chk("w6_b_vld", 64'(out_vld6), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
